uart_rx: RTL and testbench

- Synthesizable UART receiver that deserializes the asynchronous serial line driven by the external device (8N1, LSB first) into bytes.
- Presents each byte on a one-entry valid/ready holding register with framing-error and overrun reporting.
- Sits on the rx_i side of uart_top and is the receiving counterpart of the serial stream the uart_vd model transmits.

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-entry
// valid/ready holding register with framing-error and overrun pulses.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | counting to mid start bit to confirm it
// DATA      | sampling DATA_BITS data bits at mid-bit, LSB first
// STOP      | sampling the stop bit at mid-bit
// WAIT_IDLE | bad stop bit seen, waiting for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BITS_LAST = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               state, state_nxt;
  logic [BW-1:0]        baud_cnt, baud_nxt;
  logic [CW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 sync1, rx_s;
  logic                 done, done_nxt;
  logic                 ferr_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      done        <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sync1       <= rx_i;
      rx_s        <= sync1;
      state       <= state_nxt;
      baud_cnt    <= baud_nxt;
      bit_cnt     <= bit_nxt;
      shift       <= shift_nxt;
      done        <= done_nxt;
      frame_err_o <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          baud_nxt  = '0;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_nxt  = '0;
          shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
          bit_nxt   = bit_cnt + CW'(1);
          if (bit_cnt == BITS_LAST) state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_nxt = '0;
          // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
          if (rx_s) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  // A delivery in the same cycle as a handshake replaces the accepted byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= shift;
          rx_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: normal frames, back-to-back,
// glitch, framing error, overrun and mid-frame reset.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic       rx_ready_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, frame_err_o, overrun_o, busy_o;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [7:0] data_q[$];
  int         cyc_q[$];
  int         n_valid, n_ferr, n_ovr;
  logic       busy_seen, valid_d;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-high-phase
  always @(posedge clk) begin
    #5;
    if (rx_valid_o && !valid_d) begin
      n_valid++;
      data_q.push_back(rx_data_o);
      cyc_q.push_back(cyc);
    end
    valid_d = rx_valid_o;
    if (frame_err_o) n_ferr++;
    if (overrun_o)   n_ovr++;
    if (busy_o)      busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] got_data(input int i);
    return (i < data_q.size()) ? 32'(data_q[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_log();
    data_q.delete();
    cyc_q.delete();
    n_valid   = 0;
    n_ferr    = 0;
    n_ovr     = 0;
    busy_seen = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    wait_cyc(CPB);
  endtask

  // Called at a negedge; returns at a negedge with rx_i left at the stop value.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  initial begin
    valid_d = 1'b0;
    clear_log();
    wait_cyc(4);
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_data", rx_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    rst_n = 1'b1;
    wait_cyc(4);

    // single byte with latency 3 + 8 + 144
    clear_log();
    send_frame(8'hA5, 1'b1);
    wait_cyc(20);
    chk("a5_count", n_valid, 1);
    chk("a5_data", got_data(0), 32'hA5);
    chk("a5_latency_ok", (cyc_q.size() > 0) && (cyc_q[0] - start_cyc >= 154)
                         && (cyc_q[0] - start_cyc <= 156), 1);
    chk("a5_ferr", n_ferr, 0);
    chk("a5_ovr", n_ovr, 0);

    // back-to-back
    clear_log();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(20);
    chk("b2b_count", n_valid, 2);
    chk("b2b_data0", got_data(0), 32'h00);
    chk("b2b_data1", got_data(1), 32'hFF);
    chk("b2b_spacing", (cyc_q.size() > 1) ? cyc_q[1] - cyc_q[0] : -1, 160);
    chk("b2b_errs", n_ferr + n_ovr, 0);

    // glitch rejection
    clear_log();
    rx_i = 1'b0;
    wait_cyc(4);
    rx_i = 1'b1;
    wait_cyc(30);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_now", busy_o, 0);
    chk("glitch_valid", n_valid, 0);
    chk("glitch_ferr", n_ferr, 0);
    send_frame(8'h3C, 1'b1);
    wait_cyc(20);
    chk("3c_count", n_valid, 1);
    chk("3c_data", got_data(0), 32'h3C);

    // framing error then stuck-low line
    clear_log();
    send_frame(8'h55, 1'b0);
    wait_cyc(40);
    chk("ferr_busy_low", busy_o, 1);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_valid", n_valid, 0);
    rx_i = 1'b1;
    wait_cyc(20);
    chk("ferr_busy_idle", busy_o, 0);
    chk("ferr_count_after", n_ferr, 1);
    send_frame(8'h81, 1'b1);
    wait_cyc(20);
    chk("81_count", n_valid, 1);
    chk("81_data", got_data(0), 32'h81);
    chk("81_ferr", n_ferr, 1);

    // overrun with consumer stalled
    clear_log();
    rx_ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    wait_cyc(20);
    chk("ovr_valid1", rx_valid_o, 1);
    chk("ovr_data1", rx_data_o, 32'h11);
    chk("ovr_none_yet", n_ovr, 0);
    send_frame(8'h22, 1'b1);
    wait_cyc(20);
    chk("ovr_count", n_ovr, 1);
    chk("ovr_data_kept", rx_data_o, 32'h11);
    chk("ovr_valid_held", rx_valid_o, 1);
    chk("ovr_deliveries", n_valid, 1);
    rx_ready_i = 1'b1;
    wait_cyc(1);
    rx_ready_i = 1'b0;
    chk("ovr_accept", rx_valid_o, 0);
    rx_ready_i = 1'b1;
    wait_cyc(4);

    // reset in the middle of bit 4 of 0xF0 (bits 4..7 and stop are high)
    clear_log();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx_i = 1'b1;
    wait_cyc(8);
    chk("mid_busy", busy_o, 1);
    rst_n = 1'b0;
    wait_cyc(1);
    chk("mid_rst_data", rx_data_o, 0);
    chk("mid_rst_valid", rx_valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_pulses", {30'b0, frame_err_o, overrun_o}, 0);
    rst_n = 1'b1;
    wait_cyc(8 + 4 * CPB + 20);
    chk("mid_no_valid", n_valid, 0);
    chk("mid_no_err", n_ferr + n_ovr, 0);
    send_frame(8'hC3, 1'b1);
    wait_cyc(20);
    chk("c3_count", n_valid, 1);
    chk("c3_data", got_data(0), 32'hC3);
    chk("c3_errs", n_ferr + n_ovr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
